i2c_master_fsm: RTL and testbench
=================================

Name: i2c_master_fsm

Overview:
Control stage directly upstream of the I2C master datapath. It generates SCL and the per-bit edge counter. It sequences START / address / data / ACK / repeat-start / STOP phases, asserting exactly one phase enable at a time. The datapath consumes those enables and counter_detect_edge_o to shift SDA; this block samples the slave ACK from sda_i and reports status to the register/host side.

Parameters:
PRESCALER_MIN, 2, lower clamp applied to prescaler_i
PRESCALER_MAX, 85, upper clamp applied to prescaler_i (keeps 3*P-1 within 8 bits)

Ports:
i2c_core_clock_i  in  1  core clock
reset_bit_i  in  1  asynchronous reset, active-high
enable_i  in  1  start a transaction; sampled only in IDLE
addr_rw_i  in  8  {addr[6:0], rw}; bit0=1 means read; sampled at START and at REPEAT_START exit
byte_count_i  in  8  data bytes per transaction; 0 means address-only; sampled with enable_i
repeat_start_i  in  1  sampled at last-byte ACK end; 1 means REPEAT_START instead of STOP
prescaler_i  in  8  half-period P in core clocks; clamped to [2,85] internally
sda_i  in  1  SDA line input, used for ACK sampling
start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o, write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o  out  1 each  phase enables, one-hot or all zero
counter_detect_edge_o  out  8  intra-bit counter
scl_o  out  1  SCL
sda_override_en_o  out  1  1 means SDA comes from sda_override_o (STOP, REPEAT_START)
sda_override_o  out  1  override SDA value
ack_bit_o  out  1  master ACK value for the datapath (0=ACK, 1=NACK)
busy_o  out  1  high outside IDLE
byte_done_o  out  1  1-cycle pulse at end of each data-byte ACK bit
done_o  out  1  1-cycle pulse on return to IDLE
nack_o  out  1  sticky slave NACK; cleared on accepted enable_i

Behaviour:
- Reset: state IDLE; all enables 0; counter 0; scl_o=1; sda_override_en_o=1; sda_override_o=1; ack_bit_o=0; busy_o, byte_done_o, done_o, nack_o = 0. Reset mid-transaction aborts immediately to these values.
- States: IDLE, START, WR_ADDR, RD_ACK_A, WR_DATA, RD_ACK_D, RD_DATA, WR_ACK, RSTART, STOP.
- All outputs are registered. The phase enable is decoded from the state. Enables and state change together on the core-clock edge.
- Bit timing (P = clamped prescaler): counter runs 0..2P-1 in bit phases and 0..3P-1 in STOP and RSTART, then wraps to 0. Counter is held at 0 in IDLE.
  - In bit phases: scl_o=0 for counts 0..P, 1 for counts P+1..2P-1.
  - The datapath drives SDA at count P-1; ACK/data are sampled at count 2P-1.
- State transitions occur only at the final count of a phase (the "wrap"). The counter resets to 0 on every state change.
- IDLE: on enable_i=1, go to START. Latch byte_count_i into remaining; clear nack_o. enable_i while busy_o is ignored.
- START (2P cycles): scl_o=1 and sda_override_en_o=0; the datapath pulls SDA low. Next state WR_ADDR.
- WR_ADDR: internal bit counter 7..0, decremented at each wrap; after bit 0, go to RD_ACK_A.
- RD_ACK_A: sample sda_i at 2P-1.
  - sda_i=1: set nack_o, go to STOP.
  - Else if remaining=0: go to STOP.
  - Else if rw=1: go to RD_DATA; otherwise go to WR_DATA.
- WR_DATA: 8 bits, then RD_ACK_D.
- RD_ACK_D: sample the ACK, pulse byte_done_o, decrement remaining.
  - NACK: set nack_o, go to STOP.
  - remaining becomes 0: go to RSTART if repeat_start_i=1, else STOP.
  - Otherwise: go to WR_DATA.
- RD_DATA: 8 bits, then WR_ACK. Set ack_bit_o=1 when remaining=1, else 0, at entry to WR_ACK.
- WR_ACK: pulse byte_done_o, decrement remaining. Next state follows the same rules as RD_ACK_D, with no NACK check.
- RSTART (3P cycles):
  - sda_override_en_o=1 throughout.
  - sda_override_o=1 for counts 0..2P-1, 0 for counts 2P..3P-1.
  - scl_o=0 for counts 0..P, 1 for counts P+1..3P-1.
  - Then WR_ADDR. Re-latch addr_rw_i and byte_count_i.
- STOP (3P cycles):
  - sda_override_en_o=1 throughout.
  - sda_override_o=0 for counts 0..2P-1, 1 for counts 2P..3P-1.
  - scl_o=0 for counts 0..P, 1 after.
  - Then IDLE with a done_o pulse.
- Priority: reset over everything; the NACK exit overrides repeat_start_i; byte_count_i changes mid-transaction are ignored.
- prescaler_i changes take effect at the next wrap.

Test Plan:
- Reset mid-WR_DATA with P=4 -> next cycle: IDLE, scl_o=1, all enables 0, busy_o=0.
- Write 0x50 with byte_count=2, P=4, slave ACKs all -> START(8 cycles), WR_ADDR(64), RD_ACK_A(8), WR_DATA(64), RD_ACK_D(8) twice, STOP(12). Two byte_done_o pulses, one done_o pulse, nack_o=0.
- Read addr_rw=0xA1, byte_count=3 -> RD_DATA/WR_ACK x3; ack_bit_o = 0, 0, 1; then STOP.
- Slave NACK on address (sda_i=1 at count 2P-1 in RD_ACK_A) -> nack_o=1, STOP, no data phase. nack_o clears on the next enable_i.
- Write 1 byte with repeat_start_i=1, then addr_rw=0xA1 and 1 byte -> RSTART waveform as specified, read phase, final STOP.
- prescaler_i=0 and prescaler_i=200 -> bit periods of 4 and 170 core clocks respectively. enable_i pulsed while busy -> no effect.

Source files
------------

// File: rtl/i2c_master_fsm.sv
// I2C master control stage: generates SCL and the intra-bit edge counter and
// sequences the START/address/data/ACK/repeat-start/STOP phase enables.
module i2c_master_fsm #(
  parameter int unsigned PRESCALER_MIN = 2,
  parameter int unsigned PRESCALER_MAX = 85
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_i,
  input  logic       enable_i,
  input  logic [7:0] addr_rw_i,
  input  logic [7:0] byte_count_i,
  input  logic       repeat_start_i,
  input  logic [7:0] prescaler_i,
  input  logic       sda_i,
  output logic       start_cnt_o,
  output logic       write_addr_cnt_o,
  output logic       write_data_cnt_o,
  output logic       read_data_cnt_o,
  output logic       write_ack_cnt_o,
  output logic       read_ack_cnt_o,
  output logic       stop_cnt_o,
  output logic       repeat_start_cnt_o,
  output logic [7:0] counter_detect_edge_o,
  output logic       scl_o,
  output logic       sda_override_en_o,
  output logic       sda_override_o,
  output logic       ack_bit_o,
  output logic       busy_o,
  output logic       byte_done_o,
  output logic       done_o,
  output logic       nack_o
);

  localparam logic [7:0] LP_PMIN = 8'(PRESCALER_MIN);
  localparam logic [7:0] LP_PMAX = 8'(PRESCALER_MAX);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_WR_ADDR,
    S_RD_ACK_A,
    S_WR_DATA,
    S_RD_ACK_D,
    S_RD_DATA,
    S_WR_ACK,
    S_RSTART,
    S_STOP
  } state_t;

  state_t     r_state, w_state_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic [7:0] r_p, w_p_nx, w_p_clamped;
  logic [7:0] r_rem, w_rem_nx;
  logic [2:0] r_bit, w_bit_nx;
  logic       r_rw, w_rw_nx;
  logic       r_nack, w_nack_nx;
  logic       r_ack_bit, w_ack_bit_nx;
  logic       r_byte_done, w_byte_done_nx;
  logic       r_done, w_done_nx;
  logic [7:0] w_last_bit, w_last_long, w_two_p_nx;
  logic       w_long, w_wrap;
  logic [7:0] r_phase_en, w_phase_en_nx;
  logic       r_scl, w_scl_nx;
  logic       r_ovr_en, w_ovr_en_nx;
  logic       r_ovr, w_ovr_nx;
  logic       r_busy;
  logic       w_unused;

  // Address bits travel straight to the datapath; only the R/W bit steers this FSM.
  assign w_unused = &{1'b0, addr_rw_i[7:1]};

  always_comb begin
    w_p_clamped = prescaler_i;
    if (prescaler_i < LP_PMIN) begin
      w_p_clamped = LP_PMIN;
    end else if (prescaler_i > LP_PMAX) begin
      w_p_clamped = LP_PMAX;
    end
  end

  assign w_last_bit  = (r_p << 1) - 8'd1;
  assign w_last_long = r_p + (r_p << 1) - 8'd1;
  assign w_long      = (r_state == S_STOP) || (r_state == S_RSTART);
  assign w_wrap      = (r_state != S_IDLE) &&
                       (r_cnt == (w_long ? w_last_long : w_last_bit));

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = (r_state == S_IDLE) ? 8'd0 : r_cnt + 8'd1;
    w_p_nx         = r_p;
    w_rem_nx       = r_rem;
    w_bit_nx       = r_bit;
    w_rw_nx        = r_rw;
    w_nack_nx      = r_nack;
    w_ack_bit_nx   = r_ack_bit;
    w_byte_done_nx = 1'b0;
    w_done_nx      = 1'b0;
    // The half-period is only re-sampled between phases so a bit never stretches mid-way.
    if (r_state == S_IDLE || w_wrap) begin
      w_p_nx = w_p_clamped;
    end
    if (w_wrap) begin
      w_cnt_nx = 8'd0;
    end
    case (r_state)
      S_IDLE: begin
        if (enable_i) begin
          w_state_nx = S_START;
          w_rem_nx   = byte_count_i;
          w_rw_nx    = addr_rw_i[0];
          w_nack_nx  = 1'b0;
          w_bit_nx   = 3'd7;
        end
      end
      S_START: begin
        if (w_wrap) w_state_nx = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        if (w_wrap) begin
          if (r_bit == 3'd0) begin
            w_state_nx = S_RD_ACK_A;
            w_bit_nx   = 3'd7;
          end else begin
            w_bit_nx = r_bit - 3'd1;
          end
        end
      end
      S_RD_ACK_A: begin
        if (w_wrap) begin
          if (sda_i) begin
            w_nack_nx  = 1'b1;
            w_state_nx = S_STOP;
          end else if (r_rem == 8'd0) begin
            w_state_nx = S_STOP;
          end else if (r_rw) begin
            w_state_nx = S_RD_DATA;
          end else begin
            w_state_nx = S_WR_DATA;
          end
        end
      end
      S_WR_DATA: begin
        if (w_wrap) begin
          if (r_bit == 3'd0) begin
            w_state_nx = S_RD_ACK_D;
            w_bit_nx   = 3'd7;
          end else begin
            w_bit_nx = r_bit - 3'd1;
          end
        end
      end
      S_RD_ACK_D: begin
        if (w_wrap) begin
          w_byte_done_nx = 1'b1;
          w_rem_nx       = r_rem - 8'd1;
          if (sda_i) begin
            w_nack_nx  = 1'b1;
            w_state_nx = S_STOP;
          end else if (r_rem == 8'd1) begin
            w_state_nx = repeat_start_i ? S_RSTART : S_STOP;
          end else begin
            w_state_nx = S_WR_DATA;
          end
        end
      end
      S_RD_DATA: begin
        if (w_wrap) begin
          if (r_bit == 3'd0) begin
            w_state_nx   = S_WR_ACK;
            w_bit_nx     = 3'd7;
            w_ack_bit_nx = (r_rem == 8'd1);
          end else begin
            w_bit_nx = r_bit - 3'd1;
          end
        end
      end
      S_WR_ACK: begin
        if (w_wrap) begin
          w_byte_done_nx = 1'b1;
          w_rem_nx       = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_state_nx = repeat_start_i ? S_RSTART : S_STOP;
          end else begin
            w_state_nx = S_RD_DATA;
          end
        end
      end
      S_RSTART: begin
        if (w_wrap) begin
          w_state_nx = S_WR_ADDR;
          w_rw_nx    = addr_rw_i[0];
          w_rem_nx   = byte_count_i;
          w_bit_nx   = 3'd7;
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from next state/count so the registered copies line up with r_state.
  always_comb begin
    w_two_p_nx    = w_p_nx << 1;
    w_phase_en_nx = '0;
    w_scl_nx      = 1'b1;
    w_ovr_en_nx   = 1'b0;
    w_ovr_nx      = 1'b1;
    case (w_state_nx)
      S_IDLE:     w_ovr_en_nx = 1'b1;
      S_START:    w_phase_en_nx[0] = 1'b1;
      S_WR_ADDR: begin
        w_phase_en_nx[1] = 1'b1;
        w_scl_nx         = (w_cnt_nx > w_p_nx);
      end
      S_WR_DATA: begin
        w_phase_en_nx[2] = 1'b1;
        w_scl_nx         = (w_cnt_nx > w_p_nx);
      end
      S_RD_DATA: begin
        w_phase_en_nx[3] = 1'b1;
        w_scl_nx         = (w_cnt_nx > w_p_nx);
      end
      S_WR_ACK: begin
        w_phase_en_nx[4] = 1'b1;
        w_scl_nx         = (w_cnt_nx > w_p_nx);
      end
      S_RD_ACK_A, S_RD_ACK_D: begin
        w_phase_en_nx[5] = 1'b1;
        w_scl_nx         = (w_cnt_nx > w_p_nx);
      end
      S_STOP: begin
        w_phase_en_nx[6] = 1'b1;
        w_scl_nx         = (w_cnt_nx > w_p_nx);
        w_ovr_en_nx      = 1'b1;
        w_ovr_nx         = (w_cnt_nx >= w_two_p_nx);
      end
      S_RSTART: begin
        w_phase_en_nx[7] = 1'b1;
        w_scl_nx         = (w_cnt_nx > w_p_nx);
        w_ovr_en_nx      = 1'b1;
        w_ovr_nx         = (w_cnt_nx < w_two_p_nx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
    if (reset_bit_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_p         <= LP_PMIN;
      r_rem       <= '0;
      r_bit       <= 3'd7;
      r_rw        <= 1'b0;
      r_nack      <= 1'b0;
      r_ack_bit   <= 1'b0;
      r_byte_done <= 1'b0;
      r_done      <= 1'b0;
      r_phase_en  <= '0;
      r_scl       <= 1'b1;
      r_ovr_en    <= 1'b1;
      r_ovr       <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_p         <= w_p_nx;
      r_rem       <= w_rem_nx;
      r_bit       <= w_bit_nx;
      r_rw        <= w_rw_nx;
      r_nack      <= w_nack_nx;
      r_ack_bit   <= w_ack_bit_nx;
      r_byte_done <= w_byte_done_nx;
      r_done      <= w_done_nx;
      r_phase_en  <= w_phase_en_nx;
      r_scl       <= w_scl_nx;
      r_ovr_en    <= w_ovr_en_nx;
      r_ovr       <= w_ovr_nx;
      r_busy      <= (w_state_nx != S_IDLE);
    end
  end

  assign start_cnt_o           = r_phase_en[0];
  assign write_addr_cnt_o      = r_phase_en[1];
  assign write_data_cnt_o      = r_phase_en[2];
  assign read_data_cnt_o       = r_phase_en[3];
  assign write_ack_cnt_o       = r_phase_en[4];
  assign read_ack_cnt_o        = r_phase_en[5];
  assign stop_cnt_o            = r_phase_en[6];
  assign repeat_start_cnt_o    = r_phase_en[7];
  assign counter_detect_edge_o = r_cnt;
  assign scl_o                 = r_scl;
  assign sda_override_en_o     = r_ovr_en;
  assign sda_override_o        = r_ovr;
  assign ack_bit_o             = r_ack_bit;
  assign busy_o                = r_busy;
  assign byte_done_o           = r_byte_done;
  assign done_o                = r_done;
  assign nack_o                = r_nack;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Directed self-checking bench for i2c_master_fsm: phase durations, SCL/SDA
// override waveforms, ACK handling, repeat start, prescaler clamp and reset.
module tb_i2c_master_fsm;

  logic       clk = 1'b0;
  logic       reset_bit_i;
  logic       enable_i;
  logic [7:0] addr_rw_i;
  logic [7:0] byte_count_i;
  logic       repeat_start_i;
  logic [7:0] prescaler_i;
  logic       sda_i;
  logic       start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o;
  logic       write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o;
  logic [7:0] counter_detect_edge_o;
  logic       scl_o, sda_override_en_o, sda_override_o, ack_bit_o;
  logic       busy_o, byte_done_o, done_o, nack_o;
  logic [7:0] en;

  int vectors = 0;
  int miscompares = 0;
  int c_start, c_wa, c_ra, c_wd, c_rd, c_wk, c_rs, c_sp, c_bd, c_done;
  int err_wave, err_onehot, n_ack;
  logic [7:0] ack_seq;
  bit tmo;

  always #5 clk = ~clk;

  assign en = {repeat_start_cnt_o, stop_cnt_o, read_ack_cnt_o, write_ack_cnt_o,
               read_data_cnt_o, write_data_cnt_o, write_addr_cnt_o, start_cnt_o};

  i2c_master_fsm #(.PRESCALER_MIN(2), .PRESCALER_MAX(85)) dut (
    .i2c_core_clock_i     (clk),
    .reset_bit_i          (reset_bit_i),
    .enable_i             (enable_i),
    .addr_rw_i            (addr_rw_i),
    .byte_count_i         (byte_count_i),
    .repeat_start_i       (repeat_start_i),
    .prescaler_i          (prescaler_i),
    .sda_i                (sda_i),
    .start_cnt_o          (start_cnt_o),
    .write_addr_cnt_o     (write_addr_cnt_o),
    .write_data_cnt_o     (write_data_cnt_o),
    .read_data_cnt_o      (read_data_cnt_o),
    .write_ack_cnt_o      (write_ack_cnt_o),
    .read_ack_cnt_o       (read_ack_cnt_o),
    .stop_cnt_o           (stop_cnt_o),
    .repeat_start_cnt_o   (repeat_start_cnt_o),
    .counter_detect_edge_o(counter_detect_edge_o),
    .scl_o                (scl_o),
    .sda_override_en_o    (sda_override_en_o),
    .sda_override_o       (sda_override_o),
    .ack_bit_o            (ack_bit_o),
    .busy_o               (busy_o),
    .byte_done_o          (byte_done_o),
    .done_o               (done_o),
    .nack_o               (nack_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] bc, input logic [7:0] p,
                        input logic rs, input string tag);
    addr_rw_i = a; byte_count_i = bc; prescaler_i = p; repeat_start_i = rs;
    c_start = 0; c_wa = 0; c_ra = 0; c_wd = 0; c_rd = 0; c_wk = 0; c_rs = 0; c_sp = 0;
    c_bd = 0; c_done = 0; err_wave = 0; err_onehot = 0; n_ack = 0; ack_seq = '0;
    enable_i = 1'b1;
    tick();
    chk({tag, "_start_en"}, {31'd0, start_cnt_o}, 1);
    chk({tag, "_nack_clr"}, {31'd0, nack_o}, 0);
  endtask

  // Walks one transaction to its done_o pulse, tallying phase cycles and waveform errors.
  task automatic watch(input int p, input int budget, input int poke_at, output bit timeout);
    bit prev_wk;
    int cnt;
    timeout = 1'b1;
    prev_wk = 1'b0;
    for (int n = 0; n < budget; n++) begin
      enable_i = (n == poke_at);
      cnt = int'(counter_detect_edge_o);
      if ($countones(en) > 1) err_onehot++;
      if (busy_o !== (en != 8'd0)) err_onehot++;
      if (start_cnt_o) begin
        c_start++;
        if (scl_o !== 1'b1 || sda_override_en_o !== 1'b0) err_wave++;
      end
      if (en[5:1] != 5'd0) begin
        if (scl_o !== (cnt > p) || sda_override_en_o !== 1'b0 || cnt >= 2*p) err_wave++;
      end
      if (write_addr_cnt_o) c_wa++;
      if (write_data_cnt_o) c_wd++;
      if (read_data_cnt_o)  c_rd++;
      if (read_ack_cnt_o)   c_ra++;
      if (write_ack_cnt_o) begin
        c_wk++;
        if (!prev_wk) begin
          ack_seq = {ack_seq[6:0], ack_bit_o};
          n_ack++;
        end
      end
      prev_wk = write_ack_cnt_o;
      if (repeat_start_cnt_o) begin
        c_rs++;
        repeat_start_i = 1'b0;
        if (sda_override_en_o !== 1'b1 || sda_override_o !== (cnt < 2*p) ||
            scl_o !== (cnt > p) || cnt >= 3*p) err_wave++;
      end
      if (stop_cnt_o) begin
        c_sp++;
        if (sda_override_en_o !== 1'b1 || sda_override_o !== (cnt >= 2*p) ||
            scl_o !== (cnt > p) || cnt >= 3*p) err_wave++;
      end
      if (en == 8'd0) begin
        if (done_o !== 1'b1 || scl_o !== 1'b1 || sda_override_en_o !== 1'b1 ||
            sda_override_o !== 1'b1 || cnt != 0) err_wave++;
      end
      if (byte_done_o) c_bd++;
      if (done_o) begin
        c_done++;
        timeout = 1'b0;
        break;
      end
      tick();
    end
    enable_i = 1'b0;
  endtask

  task automatic expect_run(input string tag, input int s, input int wa, input int ra,
                            input int wd, input int rd, input int wk, input int rs,
                            input int sp, input int bd, input logic nk);
    chk({tag, "_done_seen"}, {31'd0, tmo}, 0);
    chk({tag, "_start_cyc"}, c_start, s);
    chk({tag, "_wr_addr_cyc"}, c_wa, wa);
    chk({tag, "_rd_ack_cyc"}, c_ra, ra);
    chk({tag, "_wr_data_cyc"}, c_wd, wd);
    chk({tag, "_rd_data_cyc"}, c_rd, rd);
    chk({tag, "_wr_ack_cyc"}, c_wk, wk);
    chk({tag, "_rstart_cyc"}, c_rs, rs);
    chk({tag, "_stop_cyc"}, c_sp, sp);
    chk({tag, "_byte_done"}, c_bd, bd);
    chk({tag, "_done_pulses"}, c_done, 1);
    chk({tag, "_wave_err"}, err_wave, 0);
    chk({tag, "_onehot_err"}, err_onehot, 0);
    chk({tag, "_nack"}, {31'd0, nack_o}, {31'd0, nk});
    chk({tag, "_busy_end"}, {31'd0, busy_o}, 0);
  endtask

  initial begin
    bit found;
    reset_bit_i = 1'b1; enable_i = 1'b0; addr_rw_i = '0; byte_count_i = '0;
    repeat_start_i = 1'b0; prescaler_i = 8'd4; sda_i = 1'b0;
    tick(); tick();
    chk("rst_enables", {24'd0, en}, 0);
    chk("rst_cnt", {24'd0, counter_detect_edge_o}, 0);
    chk("rst_scl", {31'd0, scl_o}, 1);
    chk("rst_ovr_en", {31'd0, sda_override_en_o}, 1);
    chk("rst_ovr", {31'd0, sda_override_o}, 1);
    chk("rst_status", {27'd0, ack_bit_o, busy_o, byte_done_o, done_o, nack_o}, 0);
    reset_bit_i = 1'b0;
    tick();

    // Write 0x50, two bytes; byte_count_i change mid-transaction must be ignored
    launch(8'h50, 8'd2, 8'd4, 1'b0, "wr2");
    byte_count_i = 8'd5;
    watch(4, 1000, -1, tmo);
    expect_run("wr2", 8, 64, 24, 128, 0, 0, 0, 12, 2, 1'b0);

    // Read 0xA1, three bytes: master ACK, ACK, NACK
    launch(8'hA1, 8'd3, 8'd4, 1'b0, "rd3");
    watch(4, 1000, -1, tmo);
    expect_run("rd3", 8, 64, 8, 0, 192, 24, 0, 12, 3, 1'b0);
    chk("rd3_ack_count", n_ack, 3);
    chk("rd3_ack_seq", {24'd0, ack_seq}, 32'h1);

    // Slave NACKs the address
    sda_i = 1'b1;
    launch(8'h50, 8'd2, 8'd4, 1'b0, "nack");
    watch(4, 1000, -1, tmo);
    expect_run("nack", 8, 64, 8, 0, 0, 0, 0, 12, 0, 1'b1);
    sda_i = 1'b0;

    // Write one byte, repeat start, then read one byte from 0xA1
    launch(8'h50, 8'd1, 8'd4, 1'b1, "rs");
    addr_rw_i = 8'hA1;
    byte_count_i = 8'd1;
    watch(4, 1000, -1, tmo);
    expect_run("rs", 8, 128, 24, 64, 64, 8, 12, 12, 2, 1'b0);
    chk("rs_ack_count", n_ack, 1);
    chk("rs_ack_bit", {24'd0, ack_seq}, 32'h1);

    // prescaler 0 clamps to 2; enable pulsed while busy is ignored
    launch(8'h50, 8'd0, 8'd0, 1'b0, "pmin");
    watch(2, 500, 10, tmo);
    expect_run("pmin", 4, 32, 4, 0, 0, 0, 0, 6, 0, 1'b0);
    tick(); tick();
    chk("pmin_idle_busy", {31'd0, busy_o}, 0);
    chk("pmin_idle_en", {24'd0, en}, 0);

    // prescaler 200 clamps to 85
    launch(8'h50, 8'd0, 8'd200, 1'b0, "pmax");
    watch(85, 3000, -1, tmo);
    expect_run("pmax", 170, 1360, 170, 0, 0, 0, 0, 255, 0, 1'b0);

    // Asynchronous reset in the middle of WR_DATA
    launch(8'h50, 8'd2, 8'd4, 1'b0, "rstmid");
    enable_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (write_data_cnt_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("rstmid_reached_wr_data", {31'd0, found}, 1);
    repeat (5) tick();
    #2 reset_bit_i = 1'b1;
    #1;
    chk("rstmid_enables", {24'd0, en}, 0);
    chk("rstmid_scl", {31'd0, scl_o}, 1);
    chk("rstmid_busy", {31'd0, busy_o}, 0);
    chk("rstmid_cnt", {24'd0, counter_detect_edge_o}, 0);
    chk("rstmid_ovr_en", {31'd0, sda_override_en_o}, 1);
    tick();
    reset_bit_i = 1'b0;
    tick();
    chk("rstmid_after_busy", {31'd0, busy_o}, 0);
    chk("rstmid_after_en", {24'd0, en}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
